// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer for the RV32I core: fetch/decode/exec/mem/wb
// control, memory handshakes, instret and halt/trap detection.
module core_seq_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             is_alu,
    input  logic             is_lui,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_branch,
    input  logic             is_jal,
    input  logic             is_jalr,
    input  logic             is_ecall,
    input  logic             br_taken,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic [1:0]       wb_sel,
    output logic             halted,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
    } state_t;

    localparam int            TW   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [TW-1:0]    wcnt_q, wcnt_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [7:0]       flags;
    logic             wb_act;

    assign flags = {is_ecall, is_jalr, is_jal, is_branch,
                    is_store, is_load, is_lui, is_alu};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            wcnt_q    <= '0;
            cause_q   <= 2'b00;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    // Wait counter defaults to 0 so every state change clears it.
    always_comb begin
        state_d   = state_q;
        wcnt_d    = '0;
        cause_d   = cause_q;
        instret_d = instret_q;
        unique case (state_q)
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_DECODE;
                end else if (wcnt_q == TMAX) begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            S_DECODE: begin
                if (is_ecall) begin
                    state_d = S_HALT;
                end else if (!$onehot(flags)) begin
                    state_d = S_TRAP;
                    cause_d = 2'b10;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = (is_load || is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (wcnt_q == TMAX) begin
                    state_d = S_TRAP;
                    cause_d = 2'b01;
                end else begin
                    wcnt_d = wcnt_q + TW'(1);
                end
            end
            S_WB: begin
                instret_d = instret_q + CNT_W'(1);
                state_d   = S_FETCH;
            end
            S_HALT, S_TRAP: begin
                state_d = state_q;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are gated by rst_n so they fall immediately on reset.
    always_comb begin
        imem_req = rst_n && (state_q == S_FETCH);
        dmem_req = rst_n && (state_q == S_MEM);
        wb_act   = rst_n && (state_q == S_WB);
        ir_we    = imem_req && imem_ack;
        dmem_we  = dmem_req && is_store;
        pc_we    = wb_act;
        rf_we    = wb_act && (is_alu || is_lui || is_load
                              || is_jal || is_jalr);
        pc_sel   = 2'b00;
        wb_sel   = 2'b00;
        if (wb_act) begin
            if (is_jal)                    pc_sel = 2'b10;
            else if (is_jalr)              pc_sel = 2'b11;
            else if (is_branch && br_taken) pc_sel = 2'b01;
            if (is_load)                   wb_sel = 2'b01;
            else if (is_jal || is_jalr)    wb_sel = 2'b10;
            else if (is_lui)               wb_sel = 2'b11;
        end
    end

    assign halted     = (state_q == S_HALT);
    assign trap       = (state_q == S_TRAP);
    assign trap_cause = cause_q;
    assign instret    = instret_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Randomised self-checking bench for core_seq_ctrl against a
// per-instruction outcome model.
module tb_core_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic [7:0]  fl = 8'h00;
    logic        brt = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we;
    logic [1:0]  pc_sel, wb_sel, trap_cause;
    logic        halted, trap;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;
    logic [31:0] mi = 0;

    always #5 clk = ~clk;

    core_seq_ctrl #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .is_alu(fl[0]), .is_lui(fl[1]), .is_load(fl[2]),
        .is_store(fl[3]), .is_branch(fl[4]), .is_jal(fl[5]),
        .is_jalr(fl[6]), .is_ecall(fl[7]), .br_taken(brt),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .rf_we(rf_we), .pc_we(pc_we),
        .pc_sel(pc_sel), .wb_sel(wb_sel),
        .halted(halted), .trap(trap), .trap_cause(trap_cause),
        .instret(instret)
    );

    localparam logic [7:0] ALU = 8'h01, LUI = 8'h02, LD = 8'h04,
        ST = 8'h08, BR = 8'h10, JAL = 8'h20, JALR = 8'h40, ECALL = 8'h80;

    typedef struct packed {
        logic [31:0] cycles, ir_cyc, imem, dmem, instret;
        logic dwe, rfwe, halted, trap;
        logic [1:0] pcsel, wbsel, cause;
    } obs_t;

    function automatic string fmt(input obs_t o);
        return $sformatf(
            "cyc=%0d irc=%0d im=%0d dm=%0d dwe=%0d rf=%0d pc=%0d wb=%0d h=%0d t=%0d c=%0d n=%0d",
            o.cycles, $signed(o.ir_cyc), o.imem, o.dmem, o.dwe, o.rfwe,
            o.pcsel, o.wbsel, o.halted, o.trap, o.cause, o.instret);
    endfunction

    // Outcome of one instruction from class flags and ack delays.
    function automatic obs_t model(input logic [7:0] f, input logic br,
                                   input int iw, input int dw);
        obs_t e;
        e = '0;
        e.ir_cyc = '1;
        if (iw >= 16) begin
            e.imem = 16; e.cycles = 17; e.trap = 1; e.cause = 2'd1;
            e.instret = mi;
            return e;
        end
        e.imem = iw + 1;
        e.ir_cyc = iw;
        if (f[7]) begin
            e.halted = 1; e.cycles = iw + 3;
        end else if ($countones(f) != 1) begin
            e.trap = 1; e.cause = 2'd2; e.cycles = iw + 3;
        end else if ((f & (LD | ST)) != 0 && dw >= 16) begin
            e.dwe = f[3]; e.dmem = 16; e.cycles = iw + 20;
            e.trap = 1; e.cause = 2'd1;
        end else begin
            e.cycles = iw + 4;
            if ((f & (LD | ST)) != 0) begin
                e.dwe = f[3]; e.dmem = dw + 1; e.cycles += dw + 1;
            end
            e.rfwe = (f & (ALU | LUI | LD | JAL | JALR)) != 0;
            e.pcsel = (f == JAL) ? 2'd2 : (f == JALR) ? 2'd3 :
                      (f == BR && br) ? 2'd1 : 2'd0;
            e.wbsel = (f == LD) ? 2'd1 : (f == JAL || f == JALR) ? 2'd2 :
                      (f == LUI) ? 2'd3 : 2'd0;
            mi = mi + 1;
        end
        e.instret = mi;
        return e;
    endfunction

    task automatic run_txn(input logic [7:0] f, input logic br,
                           input int iw, input int dw, output obs_t o);
        int ic = 0, dc = 0;
        bit done = 0;
        fl = f; brt = br;
        o = '0; o.ir_cyc = '1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            imem_ack = imem_req && (ic == iw);
            dmem_ack = dmem_req && (dc == dw);
            if (imem_req) ic++;
            if (dmem_req) dc++;
            #1;
            if (imem_req) o.imem = o.imem + 1;
            if (dmem_req) begin
                o.dmem = o.dmem + 1;
                o.dwe = o.dwe | dmem_we;
            end
            if (ir_we) o.ir_cyc = c;
            o.cycles = c + 1;
            if (pc_we) begin
                o.rfwe = rf_we; o.pcsel = pc_sel; o.wbsel = wb_sel;
                done = 1;
            end
            if (halted || trap) begin
                o.halted = halted; o.trap = trap; o.cause = trap_cause;
                done = 1;
            end
        end
        imem_ack = 0; dmem_ack = 0;
        @(posedge clk); #1;
        o.instret = instret;
    endtask

    task automatic do_reset();
        rst_n = 0; imem_ack = 0; dmem_ack = 0; fl = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        mi = 0;
    endtask

    task automatic test_reset();
        imem_ack = 1; fl = LD;
        #1;
        checks++;
        if ({imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we, pc_sel,
             wb_sel, halted, trap, trap_cause} !== 15'd0) begin
            errors++;
            $display("FAIL reset_outs act=%b req=0", {imem_req, dmem_req,
                     ir_we, rf_we, pc_we, halted, trap});
        end
        checks++;
        if (instret !== 32'd0) begin
            errors++; $display("FAIL reset_instret act=%0d req=0", instret);
        end
        imem_ack = 0;
        @(posedge clk); #1 rst_n = 1; #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL reset_fetch act=%b req=1", imem_req);
        end
    endtask

    task automatic test_alu();
        obs_t o, e;
        e = model(ALU, 0, 0, 0); run_txn(ALU, 0, 0, 0, o);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL add act=%s req=%s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_load_store();
        obs_t o, e;
        e = model(LD, 0, 0, 3); run_txn(LD, 0, 0, 3, o);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL lw act=%s req=%s", fmt(o), fmt(e));
        end
        e = model(ST, 0, 1, 0); run_txn(ST, 0, 1, 0, o);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL sw act=%s req=%s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_branch_jump();
        obs_t o, e;
        logic [7:0] fs [4] = '{BR, BR, JAL, JALR};
        logic bs [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            e = model(fs[i], bs[i], i, 0);
            run_txn(fs[i], bs[i], i, 0, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL brjmp%0d act=%s req=%s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_ecall();
        obs_t o, e;
        logic [31:0] n;
        e = model(ECALL, 0, 0, 0); run_txn(ECALL, 0, 0, 0, o);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL ecall act=%s req=%s", fmt(o), fmt(e));
        end
        n = mi;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); imem_ack = 1; dmem_ack = 1; #1;
            checks++;
            if ({imem_req, dmem_req, ir_we, rf_we, pc_we, halted} !== 6'b000001
                || instret !== n) begin
                errors++;
                $display("FAIL halt_hold act=%b/%0d req=000001/%0d",
                    {imem_req, dmem_req, ir_we, rf_we, pc_we, halted},
                    instret, n);
            end
        end
        do_reset();
    endtask

    task automatic test_timeout();
        obs_t o, e;
        int ws [4] = '{15, 16, 15, 16};
        for (int i = 0; i < 4; i++) begin
            if (i < 2) begin
                e = model(ALU, 0, ws[i], 0); run_txn(ALU, 0, ws[i], 0, o);
            end else begin
                e = model(LD, 0, 0, ws[i]); run_txn(LD, 0, 0, ws[i], o);
            end
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL timeout%0d act=%s req=%s", i, fmt(o), fmt(e));
            end
            if (e.trap) do_reset();
        end
    endtask

    task automatic test_illegal();
        obs_t o, e;
        int n = 0;
        e = model(ALU | LD, 0, 2, 0); run_txn(ALU | LD, 0, 2, 0, o);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL multi act=%s req=%s", fmt(o), fmt(e));
        end
        do_reset();
        e = model(8'h00, 0, 0, 0); run_txn(8'h00, 0, 0, 0, o);
        checks++;
        if (o !== e) begin
            errors++; $display("FAIL noflag act=%s req=%s", fmt(o), fmt(e));
        end
        do_reset();
        fl = LD;
        for (int c = 0; c < 30 && n < 3; c++) begin
            @(negedge clk);
            imem_ack = imem_req; dmem_ack = 0;
            #1;
            if (dmem_req) n++;
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL mem_reach act=%0d req=3", n);
        end
        imem_ack = 0;
        rst_n = 0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL midmem_rst act=%b%b req=00", dmem_req, imem_req);
        end
        @(posedge clk); #1 rst_n = 1; mi = 0; #1;
        checks++;
        if (imem_req !== 1'b1) begin
            errors++; $display("FAIL restart act=%b req=1", imem_req);
        end
        test_alu();
    endtask

    task automatic test_random();
        obs_t o, e;
        logic [7:0] f;
        int cls, a, iw, dw;
        logic br;
        for (int t = 0; t < 60; t++) begin
            cls = $urandom_range(0, 15);
            a = $urandom_range(0, 6);
            if (cls < 13) f = 8'(1) << (cls % 7);
            else if (cls == 13) f = ECALL;
            else if (cls == 14) f = 8'h00;
            else f = (8'(1) << a) | (8'(1) << ((a + 1 + $urandom_range(0, 5)) % 7));
            iw = ($urandom_range(0, 19) == 0) ? 16 : $urandom_range(0, 4);
            dw = ($urandom_range(0, 19) == 0) ? 16 : $urandom_range(0, 4);
            br = 1'($urandom);
            e = model(f, br, iw, dw);
            run_txn(f, br, iw, dw, o);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rand%0d f=%h act=%s req=%s", t, f, fmt(o), fmt(e));
            end
            if (e.halted || e.trap) do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_store();
        test_branch_jump();
        test_ecall();
        test_timeout();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
